// File: rtl/cga_dac.sv
// cga_dac: VGA DAC / palette block.
// Decodes the CPU DAC ports (PEL mask, read index, write index, data).
// Holds the 256 x 18-bit palette and serves the adapter's colour lookup.
// Optional build macro CGA_DAC_DEFAULT_PALETTE_EN: after reset an init FSM
// loads the 16 standard CGA colours (entries 16..255 cleared) while io_busy=1.
//
// Handshake: io_write / io_read are single-cycle strobes with no back-pressure.
// Read data appears on io_rdata the cycle after io_read and is held until the
// next read. While io_busy is high the CPU must not access the DAC.
module cga_dac #(
  parameter logic [15:0] PORT_BASE = 16'h03C6,
  parameter int          ENTRIES   = 256
) (
  input  logic        clock_25,
  input  logic        resetn,
  input  logic [15:0] io_address,
  input  logic        io_write,
  input  logic        io_read,
  input  logic [7:0]  io_wdata,
  output logic [7:0]  io_rdata,
  output logic        io_busy,
  input  logic [7:0]  vga_dac_address,
  output logic [31:0] vga_dac_data
);

  // Component counter states, shared by the read and write paths.
  typedef enum logic [1:0] {
    C_R = 2'd0,
    C_G = 2'd1,
    C_B = 2'd2
  } comp_t;

  typedef enum logic {
    M_WRITE = 1'b0,
    M_READ  = 1'b1
  } mode_t;

  // Palette storage: {R6, G6, B6}; never reset.
  logic [17:0] r_palette [0:ENTRIES-1];

  logic [7:0]  r_pel_mask;
  logic [7:0]  r_write_index;
  logic [7:0]  r_read_index;
  comp_t       r_comp;
  mode_t       r_mode;
  logic [5:0]  r_lat_r;
  logic [5:0]  r_lat_g;
  logic [7:0]  r_rdata;
  logic [31:0] r_vga_data;

  logic [15:0] w_off;
  logic        w_hit;
  logic        w_wr_mask;
  logic        w_wr_rdidx;
  logic        w_wr_wridx;
  logic        w_wr_data;
  logic        w_rd_data;
  logic        w_fill_active;
  logic        w_cpu_commit;
  logic [17:0] w_commit_entry;
  logic [17:0] w_rd_entry;
  logic [17:0] w_disp_entry;
  logic [7:0]  w_rd_mux;
  logic        w_pal_we;
  logic [7:0]  w_pal_waddr;
  logic [17:0] w_pal_wdata;

  // Expand a 6-bit component to 8 bits by replicating its top bits.
  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

  // Select one component of a stored entry.
  function automatic logic [5:0] pick(input logic [17:0] e, input comp_t c);
    logic [5:0] v;
    case (c)
      C_R:     v = e[17:12];
      C_G:     v = e[11:6];
      default: v = e[5:0];
    endcase
    return v;
  endfunction

  // Port decode: offset from PORT_BASE, only offsets 0..3 are ours.
  assign w_off      = io_address - PORT_BASE;
  assign w_hit      = (w_off[15:2] == 14'd0);
  assign w_wr_mask  = io_write && w_hit && (w_off[1:0] == 2'd0);
  assign w_wr_rdidx = io_write && w_hit && (w_off[1:0] == 2'd1);
  assign w_wr_wridx = io_write && w_hit && (w_off[1:0] == 2'd2);
  // Data-port writes are dropped while the default palette is being loaded.
  assign w_wr_data  = io_write && w_hit && (w_off[1:0] == 2'd3) && !w_fill_active;
  assign w_rd_data  = io_read  && w_hit && (w_off[1:0] == 2'd3);

  // The third data write commits the whole triplet in one edge.
  assign w_cpu_commit   = w_wr_data && (r_comp == C_B);
  assign w_commit_entry = {r_lat_r, r_lat_g, io_wdata[5:0]};

  assign w_rd_entry   = r_palette[r_read_index];
  assign w_disp_entry = r_palette[vga_dac_address & r_pel_mask];

`ifdef CGA_DAC_DEFAULT_PALETTE_EN
  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_FILL = 2'd1,
    I_DONE = 2'd2
  } init_t;

  init_t      r_init;
  logic [7:0] r_fill_idx;
  logic       r_busy;
  logic [17:0] w_fill_entry;

  // Standard CGA colour i as {R6,G6,B6}: base 2A per set bit, +15 for intensity,
  // except colour 6 whose green is pulled down to give brown.
  function automatic logic [17:0] cga_color(input logic [3:0] i);
    logic [5:0] lo;
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    lo = i[3] ? 6'h15 : 6'h00;
    r  = (i[2] ? 6'h2A : 6'h00) + lo;
    g  = (i[1] ? 6'h2A : 6'h00) + lo;
    b  = (i[0] ? 6'h2A : 6'h00) + lo;
    if (i == 4'd6) begin
      g = 6'h15;
    end
    return {r, g, b};
  endfunction

  assign w_fill_active = (r_init == I_FILL);
  assign w_fill_entry  = (r_fill_idx[7:4] == 4'd0) ? cga_color(r_fill_idx[3:0]) : 18'd0;
  assign io_busy       = r_busy;

  // Init FSM: one entry per cycle after reset release, busy for the whole fill.
  always_ff @(posedge clock_25) begin
    if (!resetn) begin
      r_init     <= I_IDLE;
      r_fill_idx <= 8'd0;
      r_busy     <= 1'b0;
    end else begin
      case (r_init)
        I_IDLE: begin
          r_init     <= I_FILL;
          r_fill_idx <= 8'd0;
          r_busy     <= 1'b1;
        end
        I_FILL: begin
          r_fill_idx <= r_fill_idx + 8'd1;
          if (r_fill_idx == 8'hFF) begin
            r_init <= I_DONE;
            r_busy <= 1'b0;
          end
        end
        default: begin
          r_init <= I_DONE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  // Palette write port: the fill owns it while active, otherwise CPU commits.
  always_comb begin
    w_pal_we    = w_cpu_commit;
    w_pal_waddr = r_write_index;
    w_pal_wdata = w_commit_entry;
    if (w_fill_active) begin
      w_pal_we    = 1'b1;
      w_pal_waddr = r_fill_idx;
      w_pal_wdata = w_fill_entry;
    end
  end
`else
  assign w_fill_active = 1'b0;
  assign io_busy       = 1'b0;

  // Palette write port: CPU triplet commits only.
  always_comb begin
    w_pal_we    = w_cpu_commit;
    w_pal_waddr = r_write_index;
    w_pal_wdata = w_commit_entry;
  end
`endif

  // Palette RAM write; contents deliberately not reset.
  always_ff @(posedge clock_25) begin
    if (w_pal_we) begin
      r_palette[w_pal_waddr] <= w_pal_wdata;
    end
  end

  // CPU read-data multiplexer; unknown ports read as FF.
  always_comb begin
    w_rd_mux = 8'hFF;
    if (w_hit) begin
      case (w_off[1:0])
        2'd0:    w_rd_mux = r_pel_mask;
        2'd1:    w_rd_mux = (r_mode == M_READ) ? 8'h03 : 8'h00;
        2'd2:    w_rd_mux = r_write_index;
        default: w_rd_mux = {2'b00, pick(w_rd_entry, r_comp)};
      endcase
    end
  end

  // CPU register file and component counter FSM (C_R -> C_G -> C_B -> C_R).
  always_ff @(posedge clock_25) begin
    if (!resetn) begin
      r_pel_mask    <= 8'hFF;
      r_write_index <= 8'd0;
      r_read_index  <= 8'd0;
      r_comp        <= C_R;
      r_mode        <= M_WRITE;
      r_lat_r       <= 6'd0;
      r_lat_g       <= 6'd0;
      r_rdata       <= 8'd0;
    end else begin
      if (io_read) begin
        r_rdata <= w_rd_mux;
      end
      if (w_wr_mask) begin
        r_pel_mask <= io_wdata;
      end else if (w_wr_rdidx) begin
        r_read_index <= io_wdata;
        r_comp       <= C_R;
        r_mode       <= M_READ;
      end else if (w_wr_wridx) begin
        // Also abandons any partially written triplet.
        r_write_index <= io_wdata;
        r_comp        <= C_R;
        r_mode        <= M_WRITE;
      end else if (w_wr_data) begin
        r_mode <= M_WRITE;
        case (r_comp)
          C_R: begin
            r_lat_r <= io_wdata[5:0];
            r_comp  <= C_G;
          end
          C_G: begin
            r_lat_g <= io_wdata[5:0];
            r_comp  <= C_B;
          end
          default: begin
            r_write_index <= r_write_index + 8'd1;
            r_comp        <= C_R;
          end
        endcase
      end else if (w_rd_data) begin
        case (r_comp)
          C_R:     r_comp <= C_G;
          C_G:     r_comp <= C_B;
          default: begin
            r_read_index <= r_read_index + 8'd1;
            r_comp       <= C_R;
          end
        endcase
      end
    end
  end

  // Display lookup: one registered read per cycle, old data on a same-cycle commit.
  always_ff @(posedge clock_25) begin
    if (!resetn) begin
      r_vga_data <= 32'd0;
    end else begin
      r_vga_data <= {8'h00, expand6(w_disp_entry[17:12]),
                     expand6(w_disp_entry[11:6]), expand6(w_disp_entry[5:0])};
    end
  end

  assign io_rdata     = r_rdata;
  assign vga_dac_data = r_vga_data;

endmodule
